// File: rtl/seg_demux_1x4.sv
// Registered 1-to-4 demultiplexer steering 7-segment codes into four held digit registers.
// Optional blinking of individual digits is enabled with `define SEG_DEMUX_BLINK_EN.
module seg_demux_1x4 #(
  parameter int               WIDTH     = 7,
  parameter logic [WIDTH-1:0] BLANK     = 7'b1111111,
  parameter int               BLINK_DIV = 25000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             VALID,
  input  logic [1:0]       SEL,
  input  logic             AUTO,
`ifdef SEG_DEMUX_BLINK_EN
  input  logic [3:0]       BLINK,
`endif
  output logic             READY,
  output logic             LAST,
  output logic [WIDTH-1:0] OUT0,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  output logic [WIDTH-1:0] OUT3
);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic             last_p1;
  logic [WIDTH-1:0] data_p0;
  logic [1:0]       tgt_p0;
  logic             auto_p0;
  logic [WIDTH-1:0] digit_p1 [4];
  logic             accept;

  assign accept = (state == IDLE) && VALID && !CLEAR;
  assign READY  = (state == IDLE);
  assign LAST   = last_p1;

  // Stage 0: capture the accepted code and its resolved target digit
  always_ff @(posedge clock) begin
    if (accept) begin
      data_p0 <= D_IN;
      tgt_p0  <= AUTO ? ptr : SEL;
      auto_p0 <= AUTO;
    end
  end

  // Stage 1: commit into the held digit bank; the pointer only moves on auto writes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      last_p1 <= 1'b0;
      for (int i = 0; i < 4; i++) digit_p1[i] <= BLANK;
    end else if (CLEAR) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      last_p1 <= 1'b0;
      for (int i = 0; i < 4; i++) digit_p1[i] <= BLANK;
    end else begin
      case (state)
        IDLE: begin
          last_p1 <= 1'b0;
          if (VALID) state <= COMMIT;
        end
        COMMIT: begin
          digit_p1[tgt_p0] <= data_p0;
          if (auto_p0) ptr <= ptr + 2'd1;
          last_p1 <= (tgt_p0 == 2'd3);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEG_DEMUX_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt;
  logic             phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (CLEAR) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Blanking is display-only; the stored pattern survives the off phase
  assign OUT0 = (phase && BLINK[0]) ? BLANK : digit_p1[0];
  assign OUT1 = (phase && BLINK[1]) ? BLANK : digit_p1[1];
  assign OUT2 = (phase && BLINK[2]) ? BLANK : digit_p1[2];
  assign OUT3 = (phase && BLINK[3]) ? BLANK : digit_p1[3];
`else
  assign OUT0 = digit_p1[0];
  assign OUT1 = digit_p1[1];
  assign OUT2 = digit_p1[2];
  assign OUT3 = digit_p1[3];
`endif

endmodule

// File: tb/tb_seg_demux_1x4.sv
// Randomized self-checking bench for seg_demux_1x4 against a transaction-level model,
// plus directed literal checks for reset, explicit/auto writes, back-pressure and clear.
module tb_seg_demux_1x4;

  localparam logic [6:0] BL = 7'h7F;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       CLEAR = 1'b0;
  logic [6:0] D_IN  = 7'h00;
  logic       VALID = 1'b0;
  logic [1:0] SEL   = 2'd0;
  logic       AUTO  = 1'b0;
  logic       READY, LAST;
  logic [6:0] OUT0, OUT1, OUT2, OUT3;
`ifdef SEG_DEMUX_BLINK_EN
  logic [3:0] BLINK = 4'b0000;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int last_pulses = 0;

  seg_demux_1x4 dut (
    .clock(clock), .reset(reset), .CLEAR(CLEAR), .D_IN(D_IN), .VALID(VALID),
    .SEL(SEL), .AUTO(AUTO),
`ifdef SEG_DEMUX_BLINK_EN
    .BLINK(BLINK),
`endif
    .READY(READY), .LAST(LAST),
    .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model: the display bank, the auto pointer and at most one write in flight
  logic [6:0] m_disp [4] = '{BL, BL, BL, BL};
  int         m_ptr      = 0;
  bit         m_inflight = 0;
  logic [6:0] m_wdata;
  int         m_wdigit;
  bit         m_wauto;
  bit         m_last     = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset || CLEAR) begin
      m_disp     = '{BL, BL, BL, BL};
      m_ptr      = 0;
      m_inflight = 0;
      m_last     = 0;
    end else if (m_inflight) begin
      m_disp[m_wdigit] = m_wdata;
      if (m_wauto) m_ptr = (m_ptr + 1) % 4;
      m_last     = (m_wdigit == 3);
      m_inflight = 0;
    end else begin
      m_last = 0;
      if (VALID) begin
        m_inflight = 1;
        m_wdata    = D_IN;
        m_wdigit   = AUTO ? m_ptr : int'(SEL);
        m_wauto    = AUTO;
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge
  always @(negedge clock) begin
    check("ready", READY, !m_inflight);
    check("last",  LAST,  m_last);
    check("out0",  OUT0,  m_disp[0]);
    check("out1",  OUT1,  m_disp[1]);
    check("out2",  OUT2,  m_disp[2]);
    check("out3",  OUT3,  m_disp[3]);
    if (LAST === 1'b1) last_pulses++;
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Full handshake: hold VALID until accepted, then wait for the commit edge
  task automatic write(input logic [6:0] d, input bit a, input logic [1:0] s);
    bit r;
    bit done = 0;
    D_IN = d; AUTO = a; SEL = s; VALID = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      r = READY;
      step();
      if (r) done = 1;
    end
    VALID = 1'b0;
    check("handshake_accepted", done, 1'b1);
    step();
  endtask

  task automatic do_clear();
    CLEAR = 1'b1; step(); CLEAR = 1'b0;
  endtask

  initial begin
    int p0;
    #1 reset = 1'b0;
    #2;
    check("rst_out0", OUT0, BL);
    check("rst_out1", OUT1, BL);
    check("rst_out2", OUT2, BL);
    check("rst_out3", OUT3, BL);
    check("rst_ready", READY, 1'b1);
    check("rst_last", LAST, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();

    // Explicit write to digit 2
    D_IN = 7'h24; SEL = 2'd2; AUTO = 1'b0; VALID = 1'b1;
    step();
    VALID = 1'b0;
    check("expl_busy", READY, 1'b0);
    step();
    check("expl_ready", READY, 1'b1);
    check("expl_out2", OUT2, 7'h24);
    check("expl_out0", OUT0, BL);
    check("expl_out3", OUT3, BL);
    check("expl_last", LAST, 1'b0);

    // Auto sweep starts at digit 0 since the explicit write left the pointer alone
    p0 = last_pulses;
    write(7'h40, 1'b1, 2'd3);
    write(7'h79, 1'b1, 2'd3);
    write(7'h24, 1'b1, 2'd3);
    write(7'h30, 1'b1, 2'd0);
    check("sweep_last_now", LAST, 1'b1);
    step();
    check("sweep_last_gone", LAST, 1'b0);
    check("sweep_out0", OUT0, 7'h40);
    check("sweep_out1", OUT1, 7'h79);
    check("sweep_out2", OUT2, 7'h24);
    check("sweep_out3", OUT3, 7'h30);
    check("sweep_last_pulses", last_pulses - p0, 1);
    write(7'h19, 1'b1, 2'd2);
    check("wrap_out0", OUT0, 7'h19);
    check("wrap_out1", OUT1, 7'h79);

    // Back-pressure: VALID held while D_IN changes every cycle
    do_clear();
    AUTO = 1'b1; VALID = 1'b1;
    D_IN = 7'h01; step();
    D_IN = 7'h02; step();
    D_IN = 7'h03; step();
    D_IN = 7'h04; step();
    VALID = 1'b0;
    step();
    check("bp_out0", OUT0, 7'h01);
    check("bp_out1", OUT1, 7'h03);
    check("bp_out2", OUT2, BL);

    // CLEAR wins over a simultaneous VALID
    write(7'h55, 1'b0, 2'd3);
    CLEAR = 1'b1; VALID = 1'b1; D_IN = 7'h11; AUTO = 1'b0; SEL = 2'd1;
    step();
    CLEAR = 1'b0; VALID = 1'b0;
    check("clr_idle_ready", READY, 1'b1);
    step();
    check("clr_idle_out1", OUT1, BL);
    check("clr_idle_out3", OUT3, BL);

    // CLEAR during COMMIT discards the pending write
    D_IN = 7'h22; AUTO = 1'b1; VALID = 1'b1;
    step();
    VALID = 1'b0;
    do_clear();
    check("clr_commit_out0", OUT0, BL);
    check("clr_commit_ready", READY, 1'b1);
    write(7'h33, 1'b1, 2'd2);
    check("clr_ptr_zero", OUT0, 7'h33);

    // Asynchronous reset in the middle of a commit
    D_IN = 7'h44; AUTO = 1'b0; SEL = 2'd3; VALID = 1'b1;
    step();
    VALID = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out0", OUT0, BL);
    check("arst_ready", READY, 1'b1);
    step();
    check("arst_out3", OUT3, BL);
    reset = 1'b1;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      VALID = ($urandom_range(0, 3) != 0);
      AUTO  = $urandom_range(0, 1);
      SEL   = 2'($urandom_range(0, 3));
      D_IN  = 7'($urandom_range(0, 127));
      CLEAR = ($urandom_range(0, 39) == 0);
      step();
    end
    VALID = 1'b0; CLEAR = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
